// File: rtl/tc_accum_bank.sv
// Bank of TC_NUM on-delay timers / up-counters sharing one prescaled time base, with addressed type writes and readback.
// Optional build macro TC_RETENTIVE_EN: timers hold their accumulator while disabled instead of clearing it.
module tc_accum_bank #(
  parameter int unsigned PRESET_LEN = 8,
  parameter int unsigned TC_NUM     = 7,
  parameter int unsigned ADDR_LEN   = 3,
  parameter int unsigned TICK_DIV   = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TC_NUM*PRESET_LEN-1:0] presetIn,
  input  logic [ADDR_LEN-1:0]          tcAddr,
  input  logic                         tcTypeWrEn,
  input  logic                         tcTypeIn,
  input  logic [TC_NUM-1:0]            tcEnIn,
  input  logic [TC_NUM-1:0]            tcResetIn,
  output logic [TC_NUM-1:0]            tcDone,
  output logic [PRESET_LEN-1:0]        accOut,
  output logic                         doneOut
);

  localparam int unsigned PRE_LEN = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_LEN-1:0]    PRE_LAST = PRE_LEN'(TICK_DIV - 1);
  localparam logic [PRESET_LEN-1:0] ACC_MAX  = '1;

  logic [PRE_LEN-1:0]    prescaler;
  logic                  tick;
  logic [PRESET_LEN-1:0] acc     [TC_NUM];
  logic [PRESET_LEN-1:0] accNext [TC_NUM];
  logic [PRESET_LEN-1:0] preset  [TC_NUM];
  logic [TC_NUM-1:0]     tcType;
  logic [TC_NUM-1:0]     typeNext;
  logic [TC_NUM-1:0]     doneNext;
  logic [TC_NUM-1:0]     enPrev;
  logic [PRESET_LEN-1:0] rdAcc;
  logic                  rdDone;

  // Shared time base: one tick every TICK_DIV clocks.
  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_LEN'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < TC_NUM; i++) begin
      preset[i] = presetIn[i*PRESET_LEN +: PRESET_LEN];
    end
  end

  // Per-channel next state; type write beats tcResetIn beats counting.
  always_comb begin
    typeNext = tcType;
    doneNext = '0;
    for (int unsigned i = 0; i < TC_NUM; i++) begin
      accNext[i] = acc[i];
      if (tcTypeWrEn && (32'(tcAddr) == i)) begin
        typeNext[i] = tcTypeIn;
        accNext[i]  = '0;
        doneNext[i] = 1'b0;
      end else begin
        if (tcResetIn[i]) begin
          accNext[i] = '0;
        end else if (tcType[i]) begin
          if (tcEnIn[i] && !enPrev[i] && (acc[i] != ACC_MAX)) begin
            accNext[i] = acc[i] + PRESET_LEN'(1);
          end
        end else if (tcEnIn[i]) begin
          if (tick && (acc[i] < preset[i])) begin
            accNext[i] = acc[i] + PRESET_LEN'(1);
          end
        end else begin
`ifdef TC_RETENTIVE_EN
          accNext[i] = acc[i];
`else
          accNext[i] = '0;
`endif
        end
        // Timers only report done while enabled; counters report whenever reached.
        doneNext[i] = (accNext[i] >= preset[i]) && (tcType[i] || tcEnIn[i]);
      end
    end
  end

  // Readback mux; out-of-range addresses read as zero.
  always_comb begin
    rdAcc  = '0;
    rdDone = 1'b0;
    for (int unsigned i = 0; i < TC_NUM; i++) begin
      if (32'(tcAddr) == i) begin
        rdAcc  = acc[i];
        rdDone = tcDone[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TC_NUM; i++) begin
        acc[i] <= '0;
      end
      tcType  <= '0;
      enPrev  <= '0;
      tcDone  <= '0;
      accOut  <= '0;
      doneOut <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < TC_NUM; i++) begin
        acc[i] <= accNext[i];
      end
      tcType  <= typeNext;
      enPrev  <= tcEnIn;
      tcDone  <= doneNext;
      accOut  <= rdAcc;
      doneOut <= rdDone;
    end
  end

endmodule

// File: doc/tc_accum_bank.md
TC_ACCUM_BANK -- requirements
Module: tc_accum_bank

Interface
REQ-001 SHALL have parameter PRESET_LEN, default 8, which sets the width of each preset and accumulator.
REQ-002 SHALL have parameter TC_NUM, default 7, which sets the number of timer/counter channels.
REQ-003 SHALL have parameter ADDR_LEN, default 3, which sets the channel address width.
REQ-004 SHALL have parameter TICK_DIV, default 10, which sets the clk cycles per timer base tick (minimum 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port presetIn, input, TC_NUM*PRESET_LEN, the concatenated presets with channel 0 in the LSBs.
REQ-008 SHALL have port tcAddr, input, ADDR_LEN, which selects the channel for type writes and readback.
REQ-009 SHALL have port tcTypeWrEn, input, 1, the type-write strobe.
REQ-010 SHALL have port tcTypeIn, input, 1, the channel type: 0 = on-delay timer, 1 = up-counter.
REQ-011 SHALL have port tcEnIn, input, TC_NUM, the per-channel enable (timer) or count input (counter).
REQ-012 SHALL have port tcResetIn, input, TC_NUM, the per-channel accumulator clear.
REQ-013 SHALL have port tcDone, output, TC_NUM, the registered per-channel done bits.
REQ-014 SHALL have port accOut, output, PRESET_LEN, the registered accumulator of channel tcAddr.
REQ-015 SHALL have port doneOut, output, 1, the registered done bit of channel tcAddr.

Function
REQ-016 SHALL run a prescaler from 0 to TICK_DIV-1 and wrap; tick is high in the cycle the prescaler equals TICK_DIV-1.
REQ-017 SHALL write tcTypeIn into type[tcAddr] when tcTypeWrEn=1; the same edge clears acc and done of that channel.
REQ-018 SHALL ignore a type write when tcAddr>=TC_NUM.
REQ-019 SHALL register tcEnIn into enPrev every cycle for edge detection.
REQ-020 SHALL, for a timer channel with tcEnIn=1, increment acc on tick when acc<preset and otherwise hold acc.
REQ-021 SHALL, for a timer channel with tcEnIn=0, clear acc to 0 (non-retentive; see REQ-034).
REQ-022 SHALL compute timer done_next = tcEnIn & (acc_next >= preset).
REQ-023 SHALL, for a counter channel, increment acc on a rising edge of tcEnIn (tcEnIn=1, enPrev=0), saturating at 2^PRESET_LEN-1.
REQ-024 SHALL compute counter done_next = (acc_next >= preset).
REQ-025 SHALL register tcDone from done_next, so done rises on the same edge at which acc reaches preset.
REQ-026 SHALL compare against the current presetIn every cycle; after a preset change, done SHALL re-evaluate on the next edge with no restart.
REQ-027 SHALL treat a preset of 0 as immediately satisfied: a counter's done = 1 on the first edge after reset, and a timer's done = 1 on the first edge with enable high.
REQ-028 SHALL apply per-channel priority: reset > type write > tcResetIn > increment.
REQ-029 SHALL make tcResetIn clear acc to 0 and re-evaluate done against the cleared acc on the same edge.
REQ-030 SHALL register the readback (accOut, doneOut) with 1-cycle latency from tcAddr.
REQ-031 SHALL drive accOut and doneOut to 0 when tcAddr>=TC_NUM.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, clear the prescaler, all acc, all enPrev, all type bits (all channels become timers), tcDone, accOut and doneOut to 0.
REQ-033 SHALL, when reset is asserted mid-count, discard accumulated progress; counting restarts from 0 with the prescaler phase at 0.

Configuration
REQ-034 SHALL, when macro TC_RETENTIVE_EN is defined, make timer channels retain acc while tcEnIn=0 (only tcResetIn, a type write or reset clears it), with done still gated by tcEnIn; when it is undefined, REQ-021 applies.

Verification
REQ-035 SHALL cover: TICK_DIV=10, ch0 timer, preset 3, tcEnIn[0] held 1 -> tcDone[0] rises on the edge of the 3rd tick (30 cycles after the prescaler starts at 0), then acc holds at 3.
REQ-036 SHALL cover: ch1 counter, preset 2, three rising edges on tcEnIn[1] -> acc 1,2,3; tcDone[1]=1 from the 2nd edge; pulsing tcResetIn[1] -> acc 0, done 0.
REQ-037 SHALL cover: ch0 timer at acc 2 of preset 5, tcEnIn[0] dropped -> acc 0 without TC_RETENTIVE_EN, acc 2 held with it; on re-enable, done rises after 3 (not 5) more ticks when the macro is defined.
REQ-038 SHALL cover: ch2 counter at acc 255 (PRESET_LEN=8), one more rising edge -> acc stays 255; preset lowered from 255 to 100 -> tcDone[2] stays 1.
REQ-039 SHALL cover: tcAddr=2 -> accOut/doneOut match ch2 one cycle later; tcAddr=7 -> both 0; a type write at tcAddr=7 -> no channel changes.
REQ-040 SHALL cover: reset asserted for one cycle mid-count on all channels -> all outputs 0 next cycle and all types revert to timer.
